// File: rtl/thread_scheduler_pkg.sv
// Shared definitions for the thread scheduler slice.
// Holds the thread count and ID width, the per-thread lifecycle state
// encoding, the thread-control encodings decoded from the WB strobes, and
// a helper that folds the qualified strobes into one control code.
package thread_scheduler_pkg;

  localparam int NUM_TRD = 8;
  localparam int TRD_W   = $clog2(NUM_TRD);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    RUN   = 2'd1,
    SLEEP = 2'd2
  } trd_state_t;

  typedef enum logic [2:0] {
    CTRL_NONE  = 3'b000,
    CTRL_SLEEP = 3'b001,
    CTRL_WAKE  = 3'b010,
    CTRL_KILL  = 3'b011,
    CTRL_INIT  = 3'b111
  } trd_ctrl_t;

  // Strobes are mutually exclusive; an unqualified WB slot means no action.
  function automatic trd_ctrl_t encode_ctrl(input logic vld,
                                            input logic kill,
                                            input logic sleep,
                                            input logic wake,
                                            input logic init);
    trd_ctrl_t ctrl;
    if (!vld) begin
      ctrl = CTRL_NONE;
    end else if (kill) begin
      ctrl = CTRL_KILL;
    end else if (sleep) begin
      ctrl = CTRL_SLEEP;
    end else if (wake) begin
      ctrl = CTRL_WAKE;
    end else if (init) begin
      ctrl = CTRL_INIT;
    end else begin
      ctrl = CTRL_NONE;
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Rotating-priority arbiter used for fetch thread selection.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    index that currently has highest priority
//   gnt_idx out IDX_W    first requesting index at or after ptr (wrapping);
//                        0 when nothing requests
//   gnt_vld out 1        at least one request present
// Purely combinational; the owner keeps and advances the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W:0]   idx_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic             gnt_vld_s;

  // Scan offsets from the farthest to the nearest so the nearest request
  // to ptr is the last one written and therefore wins.
  always_comb begin
    gnt_idx_s = '0;
    gnt_vld_s = 1'b0;
    idx_s     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_s = {1'b0, ptr} + (IDX_W+1)'(k);
      if (idx_s >= (IDX_W+1)'(NUM_REQ)) begin
        idx_s = idx_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (req[idx_s[IDX_W-1:0]]) begin
        gnt_idx_s = idx_s[IDX_W-1:0];
        gnt_vld_s = 1'b1;
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  assign gnt_idx = gnt_idx_s;
  assign gnt_vld = gnt_vld_s;

endmodule

// File: rtl/thread_scheduler.sv
// Per-thread lifecycle controller and round-robin fetch scheduler.
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   wb_vld            qualifies kill/sleep/wake/init_wb from write-back
//   kill, sleep       act on trd_wb (free / park)
//   wake              resumes tgt_trd_wb if it is sleeping
//   init_wb           allocates new_trd
//   fetch_rdy         fetch accepts fetch_trd this cycle
//   new_trd(_vld)     lowest-index FREE thread and its valid
//   fetch_trd(_vld)   round-robin selected RUN thread and its valid
//   run_mask          bit i set when thread i is RUN
//   sched_flush(_trd) one-cycle pulse after sleep/kill, with the thread ID
//   init_err          one-cycle pulse after an init with no FREE thread
//   all_idle          no thread is RUN
module thread_scheduler
  import thread_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_vld,
  input  logic               kill,
  input  logic               sleep,
  input  logic               wake,
  input  logic               init_wb,
  input  logic [TRD_W-1:0]   trd_wb,
  input  logic [TRD_W-1:0]   tgt_trd_wb,
  input  logic               fetch_rdy,
  output logic [TRD_W-1:0]   new_trd,
  output logic               new_trd_vld,
  output logic [TRD_W-1:0]   fetch_trd,
  output logic               fetch_vld,
  output logic [NUM_TRD-1:0] run_mask,
  output logic               sched_flush,
  output logic [TRD_W-1:0]   sched_flush_trd,
  output logic               init_err,
  output logic               all_idle
);

  trd_state_t         state_r     [NUM_TRD];
  trd_state_t         state_nxt_s [NUM_TRD];
  logic [TRD_W-1:0]   rr_ptr_r;
  logic               flush_r;
  logic [TRD_W-1:0]   flush_trd_r;
  logic               init_err_r;

  trd_ctrl_t          ctrl_s;
  logic [NUM_TRD-1:0] run_mask_s;
  logic [NUM_TRD-1:0] free_mask_s;
  logic [TRD_W-1:0]   new_trd_s;
  logic               new_trd_vld_s;
  logic [TRD_W-1:0]   fetch_trd_s;
  logic               fetch_vld_s;
  logic               flush_nxt_s;
  logic               init_err_nxt_s;

  assign ctrl_s = encode_ctrl(wb_vld, kill, sleep, wake, init_wb);

  // Derive RUN and FREE masks from the registered per-thread state.
  always_comb begin
    run_mask_s  = '0;
    free_mask_s = '0;
    for (int i = 0; i < NUM_TRD; i++) begin
      run_mask_s[i]  = (state_r[i] == RUN);
      free_mask_s[i] = (state_r[i] == FREE);
    end
  end

  // Lowest-index FREE thread; scan downward so the lowest index is written last.
  always_comb begin
    new_trd_s     = '0;
    new_trd_vld_s = 1'b0;
    for (int i = NUM_TRD - 1; i >= 0; i--) begin
      if (free_mask_s[i]) begin
        new_trd_s     = TRD_W'(i);
        new_trd_vld_s = 1'b1;
      end else begin
        new_trd_vld_s = new_trd_vld_s;
      end
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_TRD),
    .IDX_W   (TRD_W)
  ) u_fetch_arb (
    .req     (run_mask_s),
    .ptr     (rr_ptr_r),
    .gnt_idx (fetch_trd_s),
    .gnt_vld (fetch_vld_s)
  );

  // Next-state for the thread table plus the flush / init-error pulses.
  always_comb begin
    state_nxt_s    = state_r;
    flush_nxt_s    = 1'b0;
    init_err_nxt_s = 1'b0;
    case (ctrl_s)
      CTRL_INIT: begin
        if (new_trd_vld_s) begin
          state_nxt_s[new_trd_s] = RUN;
        end else begin
          init_err_nxt_s = 1'b1;
        end
      end
      CTRL_SLEEP: begin
        // The flush fires regardless: the sleeping instruction's younger
        // fetches must be discarded even if the thread was already parked.
        flush_nxt_s = 1'b1;
        if (state_r[trd_wb] == RUN) begin
          state_nxt_s[trd_wb] = SLEEP;
        end else begin
          state_nxt_s[trd_wb] = state_r[trd_wb];
        end
      end
      CTRL_WAKE: begin
        if (state_r[tgt_trd_wb] == SLEEP) begin
          state_nxt_s[tgt_trd_wb] = RUN;
        end else begin
          state_nxt_s[tgt_trd_wb] = state_r[tgt_trd_wb];
        end
      end
      CTRL_KILL: begin
        flush_nxt_s         = 1'b1;
        state_nxt_s[trd_wb] = FREE;
      end
      default: begin
        state_nxt_s = state_r;
      end
    endcase
  end

  // Thread table register: thread 0 comes out of reset running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TRD; i++) begin
        state_r[i] <= (i == 0) ? RUN : FREE;
      end
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin pointer: advance past the granted thread, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (fetch_vld_s && fetch_rdy) begin
      rr_ptr_r <= (fetch_trd_s == TRD_W'(NUM_TRD - 1)) ? '0 : fetch_trd_s + TRD_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // One-cycle flush and init-error pulses; the flush ID holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_r     <= 1'b0;
      flush_trd_r <= '0;
      init_err_r  <= 1'b0;
    end else begin
      flush_r     <= flush_nxt_s;
      flush_trd_r <= flush_nxt_s ? trd_wb : flush_trd_r;
      init_err_r  <= init_err_nxt_s;
    end
  end

  assign new_trd         = new_trd_s;
  assign new_trd_vld     = new_trd_vld_s;
  assign fetch_trd       = fetch_trd_s;
  assign fetch_vld       = fetch_vld_s;
  assign run_mask        = run_mask_s;
  assign sched_flush     = flush_r;
  assign sched_flush_trd = flush_trd_r;
  assign init_err        = init_err_r;
  assign all_idle        = ~|run_mask_s;

endmodule
